// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MMIO_WAIT = 2'd1,
    MMIO_DONE = 2'd2
  } state_t;

  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hFFFF_0000;

  // Rotate a word left by whole byte lanes (store-side alignment).
  function automatic logic [31:0] rotl_lanes(input logic [31:0] w, input logic [1:0] sh);
    logic [31:0] r;
    r = w;
    case (sh)
      2'd1:    r = {w[23:0], w[31:24]};
      2'd2:    r = {w[15:0], w[31:16]};
      2'd3:    r = {w[7:0],  w[31:8]};
      default: r = w;
    endcase
    return r;
  endfunction

  // Rotate a word right by whole byte lanes (load-side alignment).
  function automatic logic [31:0] rotr_lanes(input logic [31:0] w, input logic [1:0] sh);
    logic [31:0] r;
    r = w;
    case (sh)
      2'd1:    r = {w[7:0],  w[31:8]};
      2'd2:    r = {w[15:0], w[31:16]};
      2'd3:    r = {w[23:0], w[31:24]};
      default: r = w;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_bram.sv
// Single-port byte-enable RAM, read-first, registered read port.
module dmem_bram #(
  parameter int unsigned DEPTH_WORDS = 4096,
  localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  input  logic          re,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Lane-masked write and read-first registered read on the same address.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: BRAM below MMIO_BASE, stalled req/ack MMIO above.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS  = 4096,
  parameter logic [31:0] MMIO_BASE    = MMIO_BASE_DEFAULT,
  parameter int unsigned MMIO_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic        mem_wea,
  input  logic        mem_rea,
  input  logic [3:0]  mem_en,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_din,
  output logic [31:0] mem_dout,
  output logic        mem_hold,
  output logic        mmio_req,
  output logic        mmio_we,
  output logic [31:0] mmio_addr,
  output logic [3:0]  mmio_be,
  output logic [31:0] mmio_wdata,
  input  logic        mmio_ack,
  input  logic [31:0] mmio_rdata,
  output logic        bus_err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = $clog2(MMIO_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MMIO_TIMEOUT - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    sh;
  logic [1:0]    rd_sh;
  logic [1:0]    mmio_sh;
  logic          mmio_rd;
  logic          dout_from_bram;
  logic [31:0]   dout_q;
  logic [31:0]   bram_q;
  logic          is_mmio;
  logic          bram_go;
  logic          mmio_go;

  // Request decode and combinational stall.
  always_comb begin
    sh       = mem_addr[1:0];
    is_mmio  = (mem_addr >= MMIO_BASE);
    bram_go  = (state == IDLE) && !is_mmio;
    mmio_go  = (state == IDLE) && is_mmio && (mem_rea || mem_wea);
    mem_hold = mmio_go || (state == MMIO_WAIT);
  end

  dmem_bram #(.DEPTH_WORDS(DEPTH_WORDS)) u_bram (
    .clk   (clk),
    .addr  (mem_addr[AW+1:2]),
    .we    (bram_go && mem_wea),
    .be    (mem_en),
    .wdata (rotl_lanes(mem_din, sh)),
    .re    (bram_go && mem_rea),
    .rdata (bram_q)
  );

  // The BRAM output register is itself the load-result register, so mem_dout
  // selects it (realigned) after a BRAM load and the local register otherwise.
  assign mem_dout = dout_from_bram ? rotr_lanes(bram_q, rd_sh) : dout_q;

  // MMIO FSM, output registers and load-result source tracking.
  always_ff @(posedge clk) begin
    if (Rst) begin
      state          <= IDLE;
      cnt            <= '0;
      mmio_req       <= 1'b0;
      mmio_we        <= 1'b0;
      mmio_addr      <= '0;
      mmio_be        <= '0;
      mmio_wdata     <= '0;
      bus_err        <= 1'b0;
      dout_q         <= '0;
      dout_from_bram <= 1'b0;
      rd_sh          <= '0;
      mmio_sh        <= '0;
      mmio_rd        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mmio_go) begin
            mmio_req   <= 1'b1;
            mmio_we    <= mem_wea;
            mmio_addr  <= {mem_addr[31:2], 2'b00};
            mmio_be    <= mem_en;
            mmio_wdata <= rotl_lanes(mem_din, sh);
            mmio_rd    <= mem_rea;
            mmio_sh    <= sh;
            cnt        <= '0;
            state      <= MMIO_WAIT;
          end else if (bram_go && mem_rea) begin
            dout_from_bram <= 1'b1;
            rd_sh          <= sh;
          end
        end
        MMIO_WAIT: begin
          cnt <= cnt + 1'b1;
          if (mmio_ack) begin
            mmio_req <= 1'b0;
            if (mmio_rd) begin
              dout_q         <= rotr_lanes(mmio_rdata, mmio_sh);
              dout_from_bram <= 1'b0;
            end
            state <= MMIO_DONE;
          end else if (cnt == CNT_LAST) begin
            mmio_req <= 1'b0;
            bus_err  <= 1'b1;
            if (mmio_rd) begin
              dout_q         <= '0;
              dout_from_bram <= 1'b0;
            end
            state <= MMIO_DONE;
          end
        end
        MMIO_DONE: state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed and random BRAM traffic
// against a byte-level memory model, plus MMIO handshake/timeout/reset cases.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned TMO   = 255;

  logic        clk = 1'b0;
  logic        Rst;
  logic        mem_wea, mem_rea;
  logic [3:0]  mem_en;
  logic [31:0] mem_addr, mem_din, mem_dout;
  logic        mem_hold, mmio_req, mmio_we;
  logic [31:0] mmio_addr;
  logic [3:0]  mmio_be;
  logic [31:0] mmio_wdata;
  logic        mmio_ack;
  logic [31:0] mmio_rdata;
  logic        bus_err;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] mwords [DEPTH];
  logic [31:0] exp_dout = '0;
  int unsigned req_rises = 0;
  logic        req_prev  = 1'b0;
  int unsigned w, h;

  dmem_responder #(
    .DEPTH_WORDS (DEPTH),
    .MMIO_BASE   (32'hFFFF_0000),
    .MMIO_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .Rst(Rst), .mem_wea(mem_wea), .mem_rea(mem_rea), .mem_en(mem_en),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout), .mem_hold(mem_hold),
    .mmio_req(mmio_req), .mmio_we(mmio_we), .mmio_addr(mmio_addr), .mmio_be(mmio_be),
    .mmio_wdata(mmio_wdata), .mmio_ack(mmio_ack), .mmio_rdata(mmio_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    req_prev <= mmio_req;
    if (mmio_req && !req_prev) req_rises <= req_rises + 1;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  // Store data byte that lands in lane j when the address offset is sh.
  function automatic logic [31:0] lane_in(input logic [31:0] d, input logic [1:0] sh);
    logic [31:0] r;
    for (int j = 0; j < 4; j++) r[8*j +: 8] = d[8*((j + 4 - int'(sh)) % 4) +: 8];
    return r;
  endfunction

  // Result byte k of a load at offset sh comes from lane (k+sh) mod 4.
  function automatic logic [31:0] lane_out(input logic [31:0] wd, input logic [1:0] sh);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = wd[8*((k + int'(sh)) % 4) +: 8];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bram_op(input logic we, input logic re, input logic [3:0] en,
                         input logic [31:0] addr, input logic [31:0] din);
    int unsigned idx;
    logic [31:0] aligned;
    idx     = (addr >> 2) % DEPTH;
    aligned = lane_in(din, addr[1:0]);
    mem_wea = we; mem_rea = re; mem_en = en; mem_addr = addr; mem_din = din;
    #1;
    chk("bram_hold", {31'b0, mem_hold}, 32'd0);
    if (re) exp_dout = lane_out(mwords[idx], addr[1:0]);
    if (we) for (int j = 0; j < 4; j++) if (en[j]) mwords[idx][8*j +: 8] = aligned[8*j +: 8];
    tick();
    mem_wea = 1'b0; mem_rea = 1'b0;
    chk("bram_dout", mem_dout, exp_dout);
  endtask

  // One MMIO transaction; ack_at is the WAIT cycle that sees ack (0 = never).
  task automatic mmio_xact(input logic we, input logic re, input logic [3:0] en,
                           input logic [31:0] addr, input logic [31:0] din,
                           input logic [31:0] rd, input int unsigned ack_at,
                           output int unsigned waits, output int unsigned holds);
    mem_wea = we; mem_rea = re; mem_en = en; mem_addr = addr; mem_din = din;
    waits = 0; holds = 0;
    #1 holds += mem_hold;
    tick();
    chk("mmio_req_up", {31'b0, mmio_req}, 32'd1);
    chk("mmio_we",     {31'b0, mmio_we}, {31'b0, we});
    chk("mmio_addr",   mmio_addr, {addr[31:2], 2'b00});
    chk("mmio_be",     {28'b0, mmio_be}, {28'b0, en});
    chk("mmio_wdata",  mmio_wdata, lane_in(din, addr[1:0]));
    while (mmio_req && waits < TMO + 5) begin
      waits++;
      if (waits == ack_at) begin mmio_ack = 1'b1; mmio_rdata = rd; end
      #1 holds += mem_hold;
      tick();
      mmio_ack = 1'b0; mmio_rdata = $urandom;
    end
    chk("done_hold", {31'b0, mem_hold}, 32'd0);
    tick();
    mem_wea = 1'b0; mem_rea = 1'b0;
    chk("no_reissue", {31'b0, mmio_req}, 32'd0);
  endtask

  initial begin
    Rst = 1'b1; mem_wea = 1'b0; mem_rea = 1'b0; mem_en = '0; mem_addr = '0;
    mem_din = '0; mmio_ack = 1'b0; mmio_rdata = '0;
    tick(); tick();
    chk("rst_dout",  mem_dout, 32'd0);
    chk("rst_req",   {31'b0, mmio_req}, 32'd0);
    chk("rst_we",    {31'b0, mmio_we}, 32'd0);
    chk("rst_addr",  mmio_addr, 32'd0);
    chk("rst_be",    {28'b0, mmio_be}, 32'd0);
    chk("rst_wdata", mmio_wdata, 32'd0);
    chk("rst_err",   {31'b0, bus_err}, 32'd0);
    chk("rst_hold",  {31'b0, mem_hold}, 32'd0);
    Rst = 1'b0;

    for (int i = 0; i < DEPTH; i++) bram_op(1'b1, 1'b0, 4'hF, 32'(i * 4), $urandom);

    bram_op(1'b1, 1'b0, 4'hF, 32'h10, 32'hA1B2C3D4);
    bram_op(1'b0, 1'b1, 4'hF, 32'h10, 32'h0);
    chk("sw_lw", mem_dout, 32'hA1B2C3D4);
    bram_op(1'b1, 1'b0, 4'b0010, 32'h11, 32'h0000_00EE);
    bram_op(1'b0, 1'b1, 4'b0001, 32'h11, 32'h0);
    chk("lbu", {24'b0, mem_dout[7:0]}, 32'h0000_00EE);
    bram_op(1'b0, 1'b1, 4'hF, 32'h10, 32'h0);
    chk("lw_after_sb", mem_dout, 32'hA1B2EED4);
    bram_op(1'b1, 1'b0, 4'b1001, 32'h13, 32'h0000_1234);
    bram_op(1'b0, 1'b1, 4'b1001, 32'h13, 32'h0);
    chk("lh_wrap", {16'b0, mem_dout[15:0]}, 32'h0000_1234);
    bram_op(1'b0, 1'b1, 4'hF, 32'h10, 32'h0);
    chk("lw_after_wrap", mem_dout, 32'h34B2EE12);
    bram_op(1'b1, 1'b0, 4'hF, 32'h20, 32'h5);
    bram_op(1'b1, 1'b1, 4'hF, 32'h20, 32'h9);
    chk("read_first", mem_dout, 32'h5);
    bram_op(1'b0, 1'b1, 4'hF, 32'h20, 32'h0);
    chk("read_new", mem_dout, 32'h9);
    bram_op(1'b0, 1'b0, 4'hF, 32'h24, 32'h0);
    chk("idle_hold", mem_dout, 32'h9);
    bram_op(1'b1, 1'b0, 4'hF, 32'h10 + DEPTH * 4, 32'h0BADCAFE);
    bram_op(1'b0, 1'b1, 4'hF, 32'h10, 32'h0);
    chk("alias", mem_dout, 32'h0BADCAFE);

    repeat (300) bram_op(1'($urandom), 1'($urandom), 4'($urandom),
                         32'($urandom_range(0, 1023)), $urandom);

    mmio_xact(1'b0, 1'b1, 4'hF, 32'hFFFF_0004, 32'h0, 32'hCAFEF00D, 3, w, h);
    chk("rd_waits", w, 32'd3);
    chk("rd_holds", h, 32'd4);
    chk("rd_dout", mem_dout, 32'hCAFEF00D);
    chk("rd_one_req", req_rises, 32'd1);
    mmio_xact(1'b0, 1'b1, 4'b0011, 32'hFFFF_0006, 32'h0, 32'h1234_0000, 1, w, h);
    chk("rd_sh_dout", mem_dout, 32'h0000_1234);
    mmio_xact(1'b1, 1'b0, 4'b0010, 32'hFFFF_0009, 32'h0000_00AB, 32'hFFFF_FFFF, 2, w, h);
    chk("wr_wdata", mmio_wdata, 32'h0000_AB00);
    chk("wr_dout_kept", mem_dout, 32'h0000_1234);
    chk("req_count", req_rises, 32'd3);

    mmio_ack = 1'b1; mmio_rdata = 32'hFFFF_FFFF;
    tick();
    mmio_ack = 1'b0;
    tick();
    chk("stray_ack_dout", mem_dout, 32'h0000_1234);
    chk("stray_ack_req", {31'b0, mmio_req}, 32'd0);

    mmio_xact(1'b0, 1'b1, 4'hF, 32'hFFFF_0000, 32'h0, 32'h0, 0, w, h);
    chk("to_waits", w, TMO);
    chk("to_holds", h, TMO + 1);
    chk("to_err", {31'b0, bus_err}, 32'd1);
    chk("to_dout", mem_dout, 32'd0);
    bram_op(1'b0, 1'b1, 4'hF, 32'h20, 32'h0);
    chk("err_sticky", {31'b0, bus_err}, 32'd1);

    mem_rea = 1'b1; mem_en = 4'hF; mem_addr = 32'hFFFF_0008;
    tick(); tick();
    chk("pre_rst_req", {31'b0, mmio_req}, 32'd1);
    Rst = 1'b1; mem_rea = 1'b0;
    tick();
    Rst = 1'b0;
    chk("rst_wait_req", {31'b0, mmio_req}, 32'd0);
    chk("rst_wait_err", {31'b0, bus_err}, 32'd0);
    mmio_ack = 1'b1; mmio_rdata = 32'h1111_1111;
    tick();
    mmio_ack = 1'b0;
    chk("late_ack_dout", mem_dout, 32'd0);
    chk("late_ack_hold", {31'b0, mem_hold}, 32'd0);
    exp_dout = '0;
    bram_op(1'b0, 1'b1, 4'hF, 32'h10, 32'h0);

    mmio_xact(1'b0, 1'b1, 4'hF, 32'hFFFF_000C, 32'h0, 32'h600DF00D, TMO, w, h);
    chk("tie_waits", w, TMO);
    chk("tie_dout", mem_dout, 32'h600DF00D);
    chk("tie_err", {31'b0, bus_err}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
